// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the dcache upstream port between the load unit and store-commit buffer.
// Optional perf counters are enabled by defining DCACHE_ARB_PERF_EN.
module dcache_port_arbiter #(
  parameter int TAG_W    = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [3:0]       ld_rmask,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_gnt,
  output logic             ld_resp,
  output logic [31:0]      ld_rdata,
  output logic [TAG_W-1:0] ld_resp_tag,
  input  logic             st_req,
  input  logic             st_urgent,
  input  logic [31:0]      st_addr,
  input  logic [3:0]       st_wmask,
  input  logic [31:0]      st_wdata,
  output logic             st_gnt,
  output logic             st_resp,
  input  logic             flush,
  output logic [31:0]      dc_addr,
  output logic [3:0]       dc_rmask,
  output logic [3:0]       dc_wmask,
  output logic [31:0]      dc_wdata,
  input  logic [31:0]      dc_rdata,
  input  logic             dc_resp
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [31:0]      perf_ld_cnt,
  output logic [31:0]      perf_st_cnt,
  output logic [31:0]      perf_conflict_cnt,
  output logic [31:0]      perf_kill_cnt
`endif
);
  localparam int CW = ($clog2(MAX_WAIT + 1) < 3) ? 3 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(MAX_WAIT);
  typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_ST} state_t;
  state_t state, state_n;
  logic [CW-1:0] ld_wait, st_wait;
  logic [TAG_W-1:0] tag;
  logic kill, last_st, slot, ld_el, st_el, pick_st, ld_win, st_win;
  // slot is gated by rst so nothing issues while the arbiter is held in reset
  always_comb begin
    slot = !rst && (state == IDLE || dc_resp);
    ld_el = ld_req && !flush;
    st_el = st_req;
    pick_st = (ld_wait == MAXW) ? 1'b0 : (st_wait == MAXW) ? 1'b1 : st_urgent ? 1'b1 : !last_st;
    ld_win = slot && ld_el && !(st_el && pick_st);
    st_win = slot && st_el && !(ld_el && !pick_st);
    state_n = ld_win ? WAIT_LD : st_win ? WAIT_ST : slot ? IDLE : state;
    ld_gnt = ld_win;
    st_gnt = st_win;
    dc_addr = ld_win ? ld_addr : st_win ? st_addr : '0;
    dc_rmask = ld_win ? ld_rmask : '0;
    dc_wmask = st_win ? st_wmask : '0;
    dc_wdata = st_win ? st_wdata : '0;
    ld_resp = dc_resp && state == WAIT_LD && !kill && !flush;
    ld_rdata = ld_resp ? dc_rdata : '0;
    ld_resp_tag = tag;
    st_resp = dc_resp && state == WAIT_ST;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ld_wait <= '0;
      st_wait <= '0;
      tag <= '0;
      kill <= 1'b0;
      last_st <= 1'b1;
    end else begin
      state <= state_n;
      if (ld_win) begin
        tag <= ld_tag;
        kill <= 1'b0;
      end else if (state == WAIT_LD && flush) begin
        kill <= 1'b1;
      end
      if (ld_win || st_win) last_st <= st_win;
      ld_wait <= (ld_win || !ld_req) ? '0 : (slot && ld_el && ld_wait != MAXW) ? ld_wait + 1'b1 : ld_wait;
      st_wait <= (st_win || !st_req) ? '0 : (slot && st_el && st_wait != MAXW) ? st_wait + 1'b1 : st_wait;
    end
  end
`ifdef DCACHE_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ld_cnt <= '0;
      perf_st_cnt <= '0;
      perf_conflict_cnt <= '0;
      perf_kill_cnt <= '0;
    end else begin
      perf_ld_cnt <= perf_ld_cnt + {31'd0, ld_win};
      perf_st_cnt <= perf_st_cnt + {31'd0, st_win};
      perf_conflict_cnt <= perf_conflict_cnt + {31'd0, slot && ld_el && st_el};
      perf_kill_cnt <= perf_kill_cnt + {31'd0, dc_resp && state == WAIT_LD && (kill || flush)};
    end
  end
`endif
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed and randomized checks of dcache_port_arbiter against a transaction-level model.
module tb_dcache_port_arbiter;
  localparam int MAXW = 4;
  logic clk, rst;
  logic ld_req, st_req, st_urgent, flush, dc_resp;
  logic [31:0] ld_addr, st_addr, st_wdata, dc_rdata;
  logic [3:0] ld_rmask, st_wmask;
  logic [4:0] ld_tag;
  logic ld_gnt, ld_resp, st_gnt, st_resp;
  logic [31:0] ld_rdata, dc_addr, dc_wdata;
  logic [4:0] ld_resp_tag;
  logic [3:0] dc_rmask, dc_wmask;
  typedef struct packed {
    logic ld_gnt, ld_resp;
    logic [31:0] ld_rdata;
    logic [4:0] ld_resp_tag;
    logic st_gnt, st_resp;
    logic [31:0] dc_addr;
    logic [3:0] dc_rmask, dc_wmask;
    logic [31:0] dc_wdata;
  } outs_t;
  outs_t lit;
  bit lit_on, auto;
  string lit_name;
  int n_cmp, n_fail;
  int pend, wl, ws, due;
  bit killed, last_ld;
  logic [4:0] ptag;
  dcache_port_arbiter #(.TAG_W(5), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_tag(ld_tag),
    .ld_gnt(ld_gnt), .ld_resp(ld_resp), .ld_rdata(ld_rdata), .ld_resp_tag(ld_resp_tag),
    .st_req(st_req), .st_urgent(st_urgent), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
    .st_gnt(st_gnt), .st_resp(st_resp), .flush(flush), .dc_addr(dc_addr), .dc_rmask(dc_rmask),
    .dc_wmask(dc_wmask), .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_resp(dc_resp));
  initial clk = 0;
  always #5 clk = ~clk;
  // Model: at most one outstanding transaction (pend: 0 none, 1 load, 2 store) plus per-requester loss counts.
  always @(negedge clk) begin : checker_p
    outs_t e, a;
    int win;
    bit slot, el_l, el_s;
    a = {ld_gnt, ld_resp, ld_rdata, ld_resp_tag, st_gnt, st_resp, dc_addr, dc_rmask, dc_wmask, dc_wdata};
    e = '0;
    win = 0;
    slot = 0;
    el_l = ld_req && !flush;
    el_s = st_req;
    if (rst) begin
      pend = 0; wl = 0; ws = 0; due = 0; killed = 0; last_ld = 0; ptag = 0;
    end else begin
      slot = (pend == 0) || dc_resp;
      if (slot && el_l && el_s)
        win = (wl == MAXW) ? 1 : (ws == MAXW) ? 2 : st_urgent ? 2 : last_ld ? 2 : 1;
      else if (slot && el_l) win = 1;
      else if (slot && el_s) win = 2;
      e.ld_gnt = (win == 1);
      e.st_gnt = (win == 2);
      if (win == 1) begin e.dc_addr = ld_addr; e.dc_rmask = ld_rmask; end
      if (win == 2) begin e.dc_addr = st_addr; e.dc_wmask = st_wmask; e.dc_wdata = st_wdata; end
      e.ld_resp = dc_resp && pend == 1 && !killed && !flush;
      if (e.ld_resp) e.ld_rdata = dc_rdata;
      e.ld_resp_tag = ptag;
      e.st_resp = dc_resp && pend == 2;
    end
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model t=%0t dut=%h want=%h", $time, a, e);
    end
    if (lit_on) begin
      n_cmp++;
      if (a !== lit) begin
        n_fail++;
        $display("FAIL %s t=%0t dut=%h want=%h", lit_name, $time, a, lit);
      end
    end
    if (!rst) begin
      wl = (win == 1 || !ld_req) ? 0 : (slot && el_l) ? ((wl + 1 > MAXW) ? MAXW : wl + 1) : wl;
      ws = (win == 2 || !st_req) ? 0 : (slot && el_s) ? ((ws + 1 > MAXW) ? MAXW : ws + 1) : ws;
      if (pend == 1 && flush) killed = 1;
      if (dc_resp) pend = 0;
      if (win != 0) begin
        pend = win;
        last_ld = (win == 1);
        if (win == 1) begin ptag = ld_tag; killed = 0; end
        due = $urandom_range(1, 3);
      end else if (due > 0) due--;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    lit_on = 0;
  endtask
  task automatic clr();
    ld_req = 0; ld_addr = 0; ld_rmask = 0; ld_tag = 0; st_req = 0; st_urgent = 0;
    st_addr = 0; st_wmask = 0; st_wdata = 0; flush = 0; dc_resp = 0; dc_rdata = 0;
  endtask
  task automatic do_rst();
    rst = 1;
    clr();
    step();
    step();
    rst = 0;
  endtask
  task automatic chk(input string nm);
    lit_name = nm;
    lit_on = 1;
  endtask
  initial begin
    rst = 1; clr(); lit_on = 0; auto = 0; lit = '0; n_cmp = 0; n_fail = 0;
    repeat (3) step();
    rst = 0;
    ld_req = 1; ld_addr = 32'h1000; ld_rmask = 4'hF; ld_tag = 3;
    lit = '0; lit.ld_gnt = 1; lit.dc_addr = 32'h1000; lit.dc_rmask = 4'hF; chk("t1_issue");
    step(); ld_req = 0;
    lit = '0; lit.ld_resp_tag = 3; chk("t1_quiet");
    step(); dc_resp = 1; dc_rdata = 32'hDEADBEEF;
    lit = '0; lit.ld_resp = 1; lit.ld_rdata = 32'hDEADBEEF; lit.ld_resp_tag = 3; chk("t1_resp");
    step(); dc_resp = 0;
    do_rst();
    ld_req = 1; ld_addr = 32'h1000; ld_rmask = 4'hF; ld_tag = 1;
    st_req = 1; st_addr = 32'h2000; st_wmask = 4'h3; st_wdata = 32'h55; dc_rdata = 32'h11;
    lit = '0; lit.ld_gnt = 1; lit.dc_addr = 32'h1000; lit.dc_rmask = 4'hF; chk("t2_L0");
    step(); dc_resp = 1;
    lit = '0; lit.ld_resp = 1; lit.ld_rdata = 32'h11; lit.ld_resp_tag = 1;
    lit.st_gnt = 1; lit.dc_addr = 32'h2000; lit.dc_wmask = 4'h3; lit.dc_wdata = 32'h55; chk("t2_S1");
    step();
    lit = '0; lit.st_resp = 1; lit.ld_gnt = 1; lit.dc_addr = 32'h1000; lit.dc_rmask = 4'hF; lit.ld_resp_tag = 1; chk("t2_L2");
    step();
    lit = '0; lit.ld_resp = 1; lit.ld_rdata = 32'h11; lit.ld_resp_tag = 1;
    lit.st_gnt = 1; lit.dc_addr = 32'h2000; lit.dc_wmask = 4'h3; lit.dc_wdata = 32'h55; chk("t2_S3");
    step();
    do_rst();
    ld_req = 1; ld_addr = 32'h3000; ld_rmask = 4'h1; ld_tag = 2;
    st_req = 1; st_urgent = 1; st_addr = 32'h4000; st_wmask = 4'hF; st_wdata = 32'hCAFE; dc_rdata = 32'hA5A5A5A5;
    lit = '0; lit.st_gnt = 1; lit.dc_addr = 32'h4000; lit.dc_wmask = 4'hF; lit.dc_wdata = 32'hCAFE; chk("t3_S0");
    for (int i = 1; i < 4; i++) begin
      step(); dc_resp = 1;
      lit.st_resp = 1; chk("t3_S_urgent");
    end
    step();
    lit = '0; lit.st_resp = 1; lit.ld_gnt = 1; lit.dc_addr = 32'h3000; lit.dc_rmask = 4'h1; chk("t3_L4_forced");
    step();
    lit = '0; lit.ld_resp = 1; lit.ld_rdata = 32'hA5A5A5A5; lit.ld_resp_tag = 2;
    lit.st_gnt = 1; lit.dc_addr = 32'h4000; lit.dc_wmask = 4'hF; lit.dc_wdata = 32'hCAFE; chk("t3_S5");
    step();
    do_rst();
    ld_req = 1; ld_tag = 7; ld_addr = 32'h5000; ld_rmask = 4'hF;
    step(); ld_req = 0; flush = 1; st_req = 1; st_addr = 32'h6000; st_wmask = 4'hC; st_wdata = 32'h77;
    lit = '0; lit.ld_resp_tag = 7; chk("t4_flush_wait");
    step(); flush = 0;
    step();
    step(); dc_resp = 1; dc_rdata = 32'h12345678;
    lit = '0; lit.ld_resp_tag = 7; lit.st_gnt = 1; lit.dc_addr = 32'h6000; lit.dc_wmask = 4'hC; lit.dc_wdata = 32'h77; chk("t4_killed");
    step(); st_req = 0; ld_req = 1; flush = 1;
    lit = '0; lit.st_resp = 1; lit.ld_resp_tag = 7; chk("t5_flush_nogrant");
    step(); dc_resp = 0; st_req = 1;
    lit = '0; lit.ld_resp_tag = 7; lit.st_gnt = 1; lit.dc_addr = 32'h6000; lit.dc_wmask = 4'hC; lit.dc_wdata = 32'h77; chk("t5_flush_store");
    step(); flush = 0;
    #2; rst = 1; dc_resp = 1;
    lit = '0; chk("t6_async_rst");
    step(); rst = 0; dc_resp = 0;
    lit = '0; lit.ld_gnt = 1; lit.dc_addr = 32'h5000; lit.dc_rmask = 4'hF; chk("t6_load_first");
    step();
    do_rst();
    auto = 1;
    repeat (4000) begin
      rst = ($urandom_range(0, 299) == 0);
      ld_req = ($urandom_range(0, 9) < 8); ld_addr = $urandom; ld_rmask = 4'($urandom_range(1, 15)); ld_tag = 5'($urandom);
      st_req = ($urandom_range(0, 9) < 6); st_urgent = ($urandom_range(0, 3) == 0);
      st_addr = $urandom; st_wmask = 4'($urandom_range(1, 15)); st_wdata = $urandom;
      flush = ($urandom_range(0, 7) == 0); dc_rdata = $urandom;
      dc_resp = (due == 1) || (due == 0 && $urandom_range(0, 15) == 0);
      step();
    end
    auto = 0; rst = 0; clr();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache upstream port between the load unit and the store-commit buffer.
- Picks one requester per transaction, issues its request to the cache for one cycle, tracks the outstanding access until the cache responds, and routes the response back.
- Supports back-to-back issue in the response cycle and squashes in-flight loads on pipeline flush.
- Sits between the LSU/store buffer and the dcache request-capture stage.

Parameters:
- TAG_W, 5, width of load tag (ROB index) carried with a load and returned with its data.
- MAX_WAIT, 4, consecutive lost arbitrations after which the losing requester is forced to win.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ld_req  input  1  load request valid
- ld_addr  input  32  load address
- ld_rmask  input  4  load byte mask, nonzero when ld_req
- ld_tag  input  TAG_W  load tag
- ld_gnt  output  1  load accepted this cycle
- ld_resp  output  1  load data valid
- ld_rdata  output  32  load data
- ld_resp_tag  output  TAG_W  tag of returning load
- st_req  input  1  store request valid
- st_urgent  input  1  store buffer full; stores get priority
- st_addr  input  32  store address
- st_wmask  input  4  store byte mask, nonzero when st_req
- st_wdata  input  32  store data
- st_gnt  output  1  store accepted this cycle
- st_resp  output  1  store completed
- flush  input  1  squash in-flight/arriving load
- dc_addr  output  32  cache request address
- dc_rmask  output  4  cache read mask
- dc_wmask  output  4  cache write mask
- dc_wdata  output  32  cache write data
- dc_rdata  input  32  cache read data
- dc_resp  input  1  cache response, one cycle per accepted request

Behaviour:
- States: IDLE, WAIT_LD, WAIT_ST.
- Issue slot is open in IDLE, or in WAIT_* when dc_resp=1.
- Issue is combinational in the slot cycle:
  - Winner's addr/mask/wdata are driven on dc_*, and its gnt=1.
  - Next state is WAIT_LD or WAIT_ST.
- Outside the issue cycle, dc_rmask=dc_wmask=0 and dc_addr/dc_wdata=0.
  - Exactly one cycle of nonzero mask per transaction.
  - Loads drive dc_wmask=0 and dc_wdata=0; stores drive dc_rmask=0.
- Slot open with no eligible requester: go or stay IDLE.
- Eligibility: ld_req && !flush; st_req.
- Arbitration priority, when both are eligible:
  1. A requester whose wait counter equals MAX_WAIT.
  2. Store if st_urgent.
  3. Round-robin: the one not granted last. The last-grant pointer resets to "store", so a load wins the first tie.
- Wait counters, one per requester, 3+ bits, saturating at MAX_WAIT:
  - Increment when the requester is eligible in an open slot and loses.
  - Clear on grant, or when the requester is not requesting.
- Captured at load issue: ld_tag into tag register; kill flag cleared.
- flush while in WAIT_LD sets the kill flag.
- ld_resp = dc_resp && state==WAIT_LD && !kill && !flush.
  - ld_rdata = dc_rdata, ld_resp_tag = tag register, both combinational.
  - ld_rdata = 0 when ld_resp=0.
- st_resp = dc_resp && state==WAIT_ST. Stores are never killed.
- dc_resp in IDLE is ignored (protocol error). No outputs change.
- Latency: gnt in cycle N. The earliest resp is N+1, same as the earliest dc_resp.
- Reset, including mid-transaction:
  - State=IDLE, counters=0, kill=0, tag=0, pointer=store.
  - While rst=1, all outputs are 0.
  - The cache must be reset together with the arbiter; an in-flight response is discarded.

Optional Feature:
- Macro: DCACHE_ARB_PERF_EN.
- Defined: adds outputs perf_ld_cnt, perf_st_cnt, perf_conflict_cnt, perf_kill_cnt (32 bits each, wrap-around, reset 0). They count, respectively:
  - load grants
  - store grants
  - open slots with both requesters eligible
  - suppressed load responses
- Undefined: ports and counters are absent. Functional behaviour is identical either way.

Test Plan:
- Only ld_req, addr 0x1000, rmask 0xF, tag 3, in IDLE -> same cycle ld_gnt=1, dc_rmask=0xF, dc_addr=0x1000; next cycle dc_rmask=0. dc_resp with dc_rdata 0xDEADBEEF -> ld_resp=1, ld_rdata=0xDEADBEEF, ld_resp_tag=3.
- ld_req and st_req held continuously, dc_resp one cycle after each issue, st_urgent=0 -> grants alternate L,S,L,S. Back-to-back issue in each dc_resp cycle, with no idle cycles between.
- st_urgent=1 with ld_req held, MAX_WAIT=4 -> 4 store grants, then 5th slot goes to load (forced), then stores resume.
- Load issued tag 7, flush pulsed 1 cycle later, dc_resp 3 cycles later -> ld_resp stays 0; a store waiting is granted in the same dc_resp cycle.
- flush in the same cycle as ld_req in IDLE, with st_req=0 -> no grant, dc masks 0, state IDLE. With st_req=1 -> store granted.
- rst asserted asynchronously mid-WAIT_ST -> all outputs 0 immediately. After release: IDLE, the next ld_req and st_req tie grants the load first.
